// File: rtl/crc_feeder.sv
// Streams a byte-length job from a word source into a CRC unit,
// then captures the result and compares it with a reference value.
module crc_feeder #(
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [LEN_W-1:0] len_bytes,
  input  logic [31:0]      crc_expected,
  input  logic [31:0]      src_data,
  input  logic             src_valid,
  output logic             src_ready,
  output logic [31:0]      bus_wr,
  output logic [1:0]       bus_size,
  output logic             buffer_write_en,
  output logic             reset_chain,
  input  logic             buffer_full,
  input  logic             reset_pending,
  input  logic             read_wait,
  input  logic [31:0]      crc_out,
  output logic             busy,
  output logic             done,
  output logic [31:0]      crc_result,
  output logic             crc_match
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RESET,
    S_RST_WAIT,
    S_FEED,
    S_DRAIN,
    S_DONE
  } state_t;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  state_t           state;
  state_t           nxt;
  logic [LEN_W-1:0] rem;
  logic [LEN_W-1:0] rem_nxt;
  logic             split;
  logic             split_nxt;
  logic             drained;
  logic [31:0]      exp_q;
  logic             issue;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      rem        <= '0;
      split      <= 1'b0;
      drained    <= 1'b0;
      exp_q      <= '0;
      crc_result <= '0;
      crc_match  <= 1'b0;
    end else begin
      state   <= nxt;
      rem     <= rem_nxt;
      split   <= split_nxt;
      drained <= (state == S_DRAIN);
      if (state == S_IDLE && start)
        exp_q <= crc_expected;
      if (state == S_DRAIN && nxt == S_DONE) begin
        crc_result <= crc_out;
        crc_match  <= (crc_out == exp_q);
      end
    end
  end

  always_comb begin
    nxt             = state;
    rem_nxt         = rem;
    split_nxt       = split;
    issue           = 1'b0;
    src_ready       = 1'b0;
    buffer_write_en = 1'b0;
    bus_wr          = '0;
    bus_size        = SZ_W;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          nxt       = S_RESET;
          rem_nxt   = len_bytes;
          split_nxt = 1'b0;
        end
      end
      S_RESET: nxt = S_RST_WAIT;
      S_RST_WAIT: begin
        if (!reset_pending)
          nxt = (rem != '0) ? S_FEED : S_DRAIN;
      end
      S_FEED: begin
        issue = !buffer_full && (rem != '0) && !abort;
        // first half of a 3-byte tail keeps the word for the byte after
        src_ready = issue && !(rem == LEN_W'(3) && !split);
        if (issue && src_valid) begin
          buffer_write_en = 1'b1;
          unique case (1'b1)
            split: begin
              bus_wr    = {24'h0, src_data[23:16]};
              bus_size  = SZ_B;
              rem_nxt   = '0;
              split_nxt = 1'b0;
            end
            (rem >= LEN_W'(4)): begin
              bus_wr  = src_data;
              rem_nxt = rem - LEN_W'(4);
            end
            (rem == LEN_W'(3)): begin
              bus_wr    = {16'h0, src_data[15:0]};
              bus_size  = SZ_H;
              rem_nxt   = LEN_W'(1);
              split_nxt = 1'b1;
            end
            (rem == LEN_W'(2)): begin
              bus_wr   = {16'h0, src_data[15:0]};
              bus_size = SZ_H;
              rem_nxt  = '0;
            end
            default: begin
              bus_wr   = {24'h0, src_data[7:0]};
              bus_size = SZ_B;
              rem_nxt  = '0;
            end
          endcase
          if (rem_nxt == '0)
            nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (drained && !read_wait)
          nxt = S_DONE;
      end
      S_DONE: nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
    if (abort && state != S_IDLE) begin
      nxt       = S_IDLE;
      rem_nxt   = '0;
      split_nxt = 1'b0;
    end
  end

  assign busy        = (state != S_IDLE);
  assign done        = (state == S_DONE);
  assign reset_chain = (state == S_RESET);

endmodule

// File: tb/tb_crc_feeder.sv
// Randomised and directed jobs against a byte-stream reference model
// of the feeder's write sequence, timing and result capture.
module tb_crc_feeder;

  localparam int LEN_W = 16;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic             abort;
  logic [LEN_W-1:0] len_bytes;
  logic [31:0]      crc_expected;
  logic [31:0]      src_data;
  logic             src_valid;
  logic             src_ready;
  logic [31:0]      bus_wr;
  logic [1:0]       bus_size;
  logic             buffer_write_en;
  logic             reset_chain;
  logic             buffer_full;
  logic             reset_pending;
  logic             read_wait;
  logic [31:0]      crc_out;
  logic             busy;
  logic             done;
  logic [31:0]      crc_result;
  logic             crc_match;

  int errors = 0;
  int checks = 0;
  logic [31:0] words[$];
  logic [31:0] last_crc;
  logic        last_match;

  crc_feeder #(.LEN_W(LEN_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .len_bytes(len_bytes), .crc_expected(crc_expected),
    .src_data(src_data), .src_valid(src_valid), .src_ready(src_ready),
    .bus_wr(bus_wr), .bus_size(bus_size),
    .buffer_write_en(buffer_write_en), .reset_chain(reset_chain),
    .buffer_full(buffer_full), .reset_pending(reset_pending),
    .read_wait(read_wait), .crc_out(crc_out), .busy(busy),
    .done(done), .crc_result(crc_result), .crc_match(crc_match)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    start         = 1'b0;
    abort         = 1'b0;
    src_valid     = 1'b0;
    src_data      = '0;
    buffer_full   = 1'b0;
    reset_pending = 1'b0;
    read_wait     = 1'b0;
  endtask

  task automatic fill_random(input int len);
    words.delete();
    for (int i = 0; i < (len + 3) / 4; i++) words.push_back($urandom);
  endtask

  task automatic run_job(input int len, input int rpw, input bit rnd,
                         input int fullwin, input int abort_at,
                         input logic [31:0] exp, input logic [31:0] crcv);
    logic [31:0] ew[$];
    logic [1:0]  es[$];
    logic [31:0] gw[$];
    logic [1:0]  gs[$];
    int rem, wi, nw, idx, pops, c, first_wr, last_wr, done_c;
    bit vld, got_done, aborted;
    // reference: chop the byte stream into word/half/byte writes
    rem = len;
    wi  = 0;
    while (rem > 0) begin
      if (rem >= 4) begin
        ew.push_back(words[wi]); es.push_back(2'b10); rem -= 4; wi++;
      end else if (rem == 3) begin
        ew.push_back(words[wi] & 32'hFFFF); es.push_back(2'b01);
        ew.push_back((words[wi] >> 16) & 32'hFF); es.push_back(2'b00);
        rem = 0;
      end else if (rem == 2) begin
        ew.push_back(words[wi] & 32'hFFFF); es.push_back(2'b01); rem = 0;
      end else begin
        ew.push_back(words[wi] & 32'hFF); es.push_back(2'b00); rem = 0;
      end
    end
    nw = (len + 3) / 4;
    idx = 0; pops = 0; c = 0; first_wr = -1; last_wr = -1; done_c = -1;
    vld = 0; got_done = 0; aborted = 0;
    start        = 1'b1;
    len_bytes    = LEN_W'(len);
    crc_expected = exp;
    crc_out      = crcv;
    @(posedge clk); #1;
    start = 1'b0;
    while (!got_done && !aborted && c < 3000) begin
      if (!vld && idx < nw) vld = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
      src_valid   = vld;
      src_data    = vld ? words[idx] : $urandom;
      buffer_full = rnd ? ($urandom_range(0, 3) == 0)
                        : (fullwin >= 0 && c >= fullwin && c < fullwin + 3);
      reset_pending = (c < rpw + 1);
      read_wait     = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
      if (rnd) begin
        start     = 1'($urandom_range(0, 1));
        len_bytes = LEN_W'($urandom);
      end
      abort = (abort_at >= 0 && gw.size() >= abort_at);
      @(negedge clk);
      chk("busy_during_job", 32'(busy), 32'd1);
      chk("reset_chain_pulse", 32'(reset_chain), 32'(c == 0));
      if (buffer_full || abort)
        chk("blocked_no_wr_pop", 32'({buffer_write_en, src_ready}), 32'd0);
      if (buffer_write_en) begin
        gw.push_back(bus_wr);
        gs.push_back(bus_size);
        if (first_wr < 0) first_wr = c;
        last_wr = c;
      end else begin
        chk("idle_bus_wr", bus_wr, 32'd0);
        chk("idle_bus_size", 32'(bus_size), 32'd2);
      end
      if (src_valid && src_ready) begin
        pops++; vld = 0; idx++;
      end
      if (done) begin
        got_done = 1; done_c = c;
      end
      if (abort) aborted = 1;
      @(posedge clk); #1;
      c++;
    end
    idle_inputs();
    chk("job_terminated", 32'(got_done || aborted), 32'd1);
    chk("busy_after_job", 32'(busy), 32'd0);
    if (aborted) begin
      chk("abort_no_done", 32'(got_done), 32'd0);
      chk("abort_wr_count", 32'(gw.size()), 32'(abort_at));
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        chk("abort_done_low", 32'(done), 32'd0);
      end
      chk("abort_crc_kept", crc_result, last_crc);
      chk("abort_match_kept", 32'(crc_match), 32'(last_match));
      @(posedge clk); #1;
    end else begin
      chk("crc_result", crc_result, crcv);
      chk("crc_match", 32'(crc_match), 32'(exp == crcv));
      last_crc   = crcv;
      last_match = (exp == crcv);
      chk("wr_count", 32'(gw.size()), 32'(ew.size()));
      for (int i = 0; i < ew.size() && i < gw.size(); i++) begin
        chk($sformatf("wr_data[%0d]", i), gw[i], ew[i]);
        chk($sformatf("wr_size[%0d]", i), 32'(gs[i]), 32'(es[i]));
      end
      chk("pop_count", 32'(pops), 32'(nw));
      if (first_wr >= 0)
        chk("wr_after_rst_wait", 32'(first_wr >= rpw + 2), 32'd1);
      if (!rnd) begin
        if (len == 0) chk("done_latency_len0", 32'(done_c), 32'(rpw + 4));
        else chk("done_latency", 32'(done_c), 32'(last_wr + 3));
        if (fullwin < 0 && len > 0) begin
          chk("first_wr_cycle", 32'(first_wr), 32'(rpw + 2));
          chk("wr_back_to_back", 32'(last_wr - first_wr), 32'(gw.size() - 1));
        end
      end
    end
  endtask

  initial begin
    idle_inputs();
    len_bytes    = '0;
    crc_expected = '0;
    crc_out      = '0;
    last_crc     = '0;
    last_match   = 1'b0;
    rst_n        = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_reset_chain", 32'(reset_chain), 32'd0);
    chk("rst_wr_en", 32'(buffer_write_en), 32'd0);
    chk("rst_src_ready", 32'(src_ready), 32'd0);
    chk("rst_bus_wr", bus_wr, 32'd0);
    chk("rst_bus_size", 32'(bus_size), 32'd2);
    chk("rst_crc_result", crc_result, 32'd0);
    chk("rst_crc_match", 32'(crc_match), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    fill_random(8);
    run_job(8, 0, 0, -1, -1, 32'hDEADBEEF, 32'hDEADBEEF);

    // asynchronous reset in the middle of a job
    fill_random(8);
    start = 1'b1; len_bytes = 16'd8; crc_expected = 32'h1;
    @(posedge clk); #1;
    start = 1'b0; src_valid = 1'b1; src_data = words[0];
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_busy", 32'(busy), 32'd0);
    chk("async_rst_wr_en", 32'(buffer_write_en), 32'd0);
    chk("async_rst_bus_size", 32'(bus_size), 32'd2);
    chk("async_rst_crc", crc_result, 32'd0);
    last_crc = '0; last_match = 1'b0;
    idle_inputs();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    words.delete();
    words.push_back(32'h44332211);
    words.push_back(32'h00776655);
    run_job(7, 1, 0, -1, -1, 32'h0, 32'h5A5A5A5A);

    fill_random(12);
    run_job(12, 0, 0, 3, -1, 32'hCAFEF00D, 32'hCAFEF00D);

    words.delete();
    run_job(0, 2, 0, -1, -1, 32'hFFFFFFFF, 32'hFFFFFFFF);

    fill_random(16);
    run_job(16, 0, 0, -1, 1, 32'h0BADBEEF, 32'h0BADBEEF);
    fill_random(6);
    run_job(6, 0, 0, -1, -1, 32'h13572468, 32'h13572468);

    fill_random(5);
    run_job(5, 0, 0, -1, -1, 32'h12345678, 32'hCBF43926);
    for (int t = 1; t <= 5; t++) begin
      fill_random(t);
      run_job(t, t % 3, 0, -1, -1, 32'h0, 32'(t));
    end

    for (int j = 0; j < 20; j++) begin
      int          len;
      logic [31:0] cv;
      len = $urandom_range(0, 40);
      cv  = $urandom;
      fill_random(len);
      run_job(len, $urandom_range(0, 3), 1, -1, -1,
              ($urandom_range(0, 1) != 0) ? cv : 32'($urandom), cv);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/crc_feeder.md
CRC_FEEDER -- requirements
Module: crc_feeder

Interface
REQ-001 Parameter LEN_W, default 16: width of the job byte-length field.
REQ-002 clk  input  1  single clock; all state changes on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 start  input  1  job launch pulse; sampled in IDLE only.
REQ-005 abort  input  1  cancel job; returns to IDLE without done.
REQ-006 len_bytes  input  LEN_W  job length in bytes; captured on accepted start.
REQ-007 crc_expected  input  32  reference CRC; captured on accepted start.
REQ-008 src_data  input  32  source word; little-endian, byte 0 in [7:0].
REQ-009 src_valid  input  1  source word available.
REQ-010 src_ready  output  1  feeder pops src_data when src_valid && src_ready.
REQ-011 bus_wr  output  32  data to the CRC unit; valid bytes right-aligned.
REQ-012 bus_size  output  2  write size: 2'b00 byte, 2'b01 halfword, 2'b10 word.
REQ-013 buffer_write_en  output  1  write strobe to the CRC unit.
REQ-014 reset_chain  output  1  one-cycle CRC chain restart request.
REQ-015 buffer_full  input  1  CRC unit input buffer full; no write may issue while high.
REQ-016 reset_pending  input  1  CRC unit restart in progress.
REQ-017 read_wait  input  1  CRC result not yet valid.
REQ-018 crc_out  input  32  CRC unit result.
REQ-019 busy  output  1  high in every state except IDLE.
REQ-020 done  output  1  one-cycle pulse at job completion.
REQ-021 crc_result  output  32  CRC captured at completion; holds until next completion.
REQ-022 crc_match  output  1  crc_result == captured crc_expected; updated with done.

Function
REQ-023 FSM states IDLE, RESET, RST_WAIT, FEED, DRAIN, DONE.
REQ-024 IDLE->RESET on start; length and expected value latched on that edge.
REQ-025 RESET lasts exactly one cycle with reset_chain=1, then RST_WAIT.
REQ-026 RST_WAIT exits when reset_pending=0, no earlier than the cycle after RESET; goes to FEED if length>0, else DRAIN.
REQ-027 FEED: src_ready = !buffer_full && remaining>0 && not in mid-tail split; buffer_write_en = issue condition && src_valid; bus_wr/bus_size are combinational from src_data and the remaining count.
REQ-028 Remaining >=4: word write, pop, remaining -= 4.
REQ-029 Remaining 2: halfword write of src_data[15:0], pop. Remaining 1: byte write of src_data[7:0], pop.
REQ-030 Remaining 3: halfword write of src_data[15:0] without pop; next eligible cycle, byte write of src_data[23:16] on bus_wr[7:0] with pop; src_valid and src_data are held by the source between the two writes.
REQ-031 Unused bus_wr bytes are driven 0; bus_wr = 0 and bus_size = 2'b10 whenever buffer_write_en = 0.
REQ-032 buffer_full=1 suppresses every write and pop that cycle, including the second half of a 3-byte split.
REQ-033 FEED->DRAIN on the edge of the final write.
REQ-034 DRAIN ignores read_wait in its first cycle; afterwards read_wait=0 moves to DONE, capturing crc_out into crc_result and setting crc_match on that edge.
REQ-035 DONE lasts one cycle with done=1, then IDLE.
REQ-036 abort in any non-IDLE state forces IDLE on the next edge.
- No done pulse; crc_result and crc_match unchanged.
- Any further write that cycle is suppressed.
- abort takes priority over all other transitions.
REQ-037 start while busy is ignored.

Reset
REQ-038 rst_n=0 asynchronously forces IDLE, clears the remaining count and split flag, and drives all outputs to 0 except bus_size=2'b10.

Verification
REQ-039 len=8, src_valid always 1, buffer_full=0 -> reset_chain pulse, then two consecutive word writes; done, crc_result=crc_out; crc_match=1 when crc_expected equals crc_out.
REQ-040 len=7, words 0x44332211 and 0x00776655 -> writes (0x44332211, 2'b10), (0x00006655, 2'b01), (0x00000077, 2'b00), in that order; exactly two pops.
REQ-041 buffer_full held 1 for 3 cycles mid-job -> no buffer_write_en and no pop in those cycles; total write count unchanged.
REQ-042 len=0, reset_pending high 2 cycles, read_wait low -> no writes; done follows; crc_result equals crc_out (init value).
REQ-043 abort during FEED after one word -> IDLE next cycle, busy=0, no done, crc_result unchanged; a new start runs normally.
REQ-044 crc_expected=0x12345678, crc_out=0xCBF43926 at completion -> done=1, crc_match=0, crc_result=0xCBF43926.
